// File: rtl/selen_mem_pkg.sv
// Shared memory-fetch definitions: FSM encoding, error data default, address fields.
package selen_mem_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ROM_ADDR_W   = 16;
  localparam int unsigned ADDR_IDX_LSB = 2;
  localparam int unsigned ADDR_IDX_MSB = 17;
  localparam int unsigned ADDR_HI_LSB  = 18;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/rom_fetch_ctrl.sv
// Core-to-ROM fetch controller: one outstanding request, registered outputs.
// Optional ACCESS watchdog enabled by defining ROM_FETCH_CTRL_TIMEOUT_EN.
module rom_fetch_ctrl
  import selen_mem_pkg::*;
#(
  parameter int unsigned       ROM_WORDS = 7,
  parameter int unsigned       TIMEOUT   = 15,
  parameter logic [DATA_W-1:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  req_val_i,
  output logic                  req_rdy_o,
  input  logic [DATA_W-1:0]     req_addr_i,
  output logic                  rsp_val_o,
  input  logic                  rsp_rdy_i,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  rom_stb_o,
  output logic [ROM_ADDR_W-1:0] rom_addr_o,
  input  logic                  rom_ack_i,
  input  logic [DATA_W-1:0]     rom_data_i
);

  if (TIMEOUT == 0 || ROM_WORDS == 0) begin : g_param_check
    $error("rom_fetch_ctrl: TIMEOUT and ROM_WORDS must be non-zero");
  end

  logic [1:0]            state_q, state_d;
  logic                  req_rdy_d, rsp_val_d, rsp_err_d, rom_stb_d;
  logic [DATA_W-1:0]     rsp_data_d;
  logic [ROM_ADDR_W-1:0] rom_addr_d;
  logic [ROM_ADDR_W-1:0] req_idx;
  logic                  req_bad;

`ifdef ROM_FETCH_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Request decode: misaligned, above the word field, or past the last ROM word.
  assign req_idx = req_addr_i[ADDR_IDX_MSB:ADDR_IDX_LSB];
  assign req_bad = (req_addr_i[ADDR_IDX_LSB-1:0] != '0) ||
                   (req_addr_i[DATA_W-1:ADDR_HI_LSB] != '0) ||
                   (32'(req_idx) >= ROM_WORDS);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      req_rdy_o  <= 1'b1;
      rsp_val_o  <= 1'b0;
      rsp_err_o  <= 1'b0;
      rsp_data_o <= '0;
      rom_stb_o  <= 1'b0;
      rom_addr_o <= '0;
`ifdef ROM_FETCH_CTRL_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_rdy_o  <= req_rdy_d;
      rsp_val_o  <= rsp_val_d;
      rsp_err_o  <= rsp_err_d;
      rsp_data_o <= rsp_data_d;
      rom_stb_o  <= rom_stb_d;
      rom_addr_o <= rom_addr_d;
`ifdef ROM_FETCH_CTRL_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next state and next registered outputs; rom_ack_i only matters in ACCESS.
  always_comb begin
    state_d    = state_q;
    req_rdy_d  = req_rdy_o;
    rsp_val_d  = rsp_val_o;
    rsp_err_d  = rsp_err_o;
    rsp_data_d = rsp_data_o;
    rom_stb_d  = rom_stb_o;
    rom_addr_d = rom_addr_o;
`ifdef ROM_FETCH_CTRL_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_val_i && req_rdy_o) begin
          req_rdy_d  = 1'b0;
          rom_addr_d = req_idx;
          if (req_bad) begin
            state_d    = ST_RESP;
            rsp_val_d  = 1'b1;
            rsp_err_d  = 1'b1;
            rsp_data_d = ERR_DATA;
          end else begin
            state_d   = ST_ACCESS;
            rom_stb_d = 1'b1;
`ifdef ROM_FETCH_CTRL_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end
        end
      end
      ST_ACCESS: begin
        if (rom_ack_i) begin
          state_d    = ST_RESP;
          rom_stb_d  = 1'b0;
          rsp_val_d  = 1'b1;
          rsp_err_d  = 1'b0;
          rsp_data_d = rom_data_i;
        end
`ifdef ROM_FETCH_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = ST_RESP;
          rom_stb_d  = 1'b0;
          rsp_val_d  = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (rsp_rdy_i) begin
          state_d   = ST_IDLE;
          rsp_val_d = 1'b0;
          rsp_err_d = 1'b0;
          req_rdy_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        req_rdy_d = 1'b1;
        rsp_val_d = 1'b0;
        rsp_err_d = 1'b0;
        rom_stb_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed scoreboard bench for rom_fetch_ctrl (timeout cases under ROM_FETCH_CTRL_TIMEOUT_EN).
module tb_rom_fetch_ctrl;

  localparam int unsigned ROM_WORDS = 7;
  localparam int unsigned TIMEOUT   = 15;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        req_val_i = 1'b0;
  logic        req_rdy_o;
  logic [31:0] req_addr_i = '0;
  logic        rsp_val_o;
  logic        rsp_rdy_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        rom_stb_o;
  logic [15:0] rom_addr_o;
  logic        rom_ack_i = 1'b0;
  logic [31:0] rom_data_i = '0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  rom_fetch_ctrl #(.ROM_WORDS(ROM_WORDS), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEADBEEF)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_val_i  (req_val_i),
    .req_rdy_o  (req_rdy_o),
    .req_addr_i (req_addr_i),
    .rsp_val_o  (rsp_val_o),
    .rsp_rdy_i  (rsp_rdy_i),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .rom_stb_o  (rom_stb_o),
    .rom_addr_o (rom_addr_o),
    .rom_ack_i  (rom_ack_i),
    .rom_data_i (rom_data_i)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"},  64'(req_rdy_o),  64'(1));
    check({tag, "_rsp_val"},  64'(rsp_val_o),  64'(0));
    check({tag, "_rsp_err"},  64'(rsp_err_o),  64'(0));
    check({tag, "_rsp_data"}, 64'(rsp_data_o), 64'(0));
    check({tag, "_rom_stb"},  64'(rom_stb_o),  64'(0));
    check({tag, "_rom_addr"}, 64'(rom_addr_o), 64'(0));
  endtask

  // One complete transaction from IDLE; ack_at is the cycle offset from transfer
  // at which rom_ack_i is high (negative: never).
  task automatic do_read(input logic [31:0] addr, input int ack_at, input logic [31:0] rdata,
                         input int hold, input logic exp_to);
    rsp_t exp, got;
    logic err_req, acc_ok, hold_ok;
    int   c, lat;
    err_req  = (addr[1:0] != 2'b00) || (addr[31:18] != 14'd0) || (32'(addr[17:2]) >= ROM_WORDS);
    exp.err  = err_req | exp_to;
    exp.data = exp.err ? 32'hDEADBEEF : rdata;
    sb_q.push_back(exp);
    lat = err_req ? 1 : (exp_to ? int'(TIMEOUT) + 1 : ack_at + 1);

    req_addr_i = addr;
    req_val_i  = 1'b1;
    check("req_rdy_idle", 64'(req_rdy_o), 64'(1));
    tick;
    req_val_i  = 1'b0;
    req_addr_i = 32'h0000_0BAD;
    c = 1;
    acc_ok = 1'b1;
    while (!rsp_val_o && c < 60) begin
      if (err_req && rom_stb_o) acc_ok = 1'b0;
      if (!err_req && (rom_stb_o !== 1'b1 || rom_addr_o !== addr[17:2])) acc_ok = 1'b0;
      if (req_rdy_o !== 1'b0) acc_ok = 1'b0;
      rom_ack_i  = (c == ack_at);
      rom_data_i = (c == ack_at) ? rdata : 32'h0BAD_0BAD;
      tick;
      c++;
    end
    rom_ack_i = 1'b0;
    check("access_phase", 64'(acc_ok), 64'(1));
    check("rsp_valid", 64'(rsp_val_o), 64'(1));
    check("latency", 64'(c), 64'(lat));
    check("stb_off_in_resp", 64'(rom_stb_o), 64'(0));
    got = {rsp_err_o, rsp_data_o};
    exp = sb_q.pop_front();
    check("rsp_data", 64'(got.data), 64'(exp.data));
    check("rsp_err", 64'(got.err), 64'(exp.err));

    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (rsp_val_o !== 1'b1 || rsp_data_o !== exp.data || rsp_err_o !== exp.err || req_rdy_o !== 1'b0)
        hold_ok = 1'b0;
      rom_ack_i  = 1'b1;
      rom_data_i = $urandom;
      tick;
    end
    rom_ack_i = 1'b0;
    if (hold > 0) begin
      if (rsp_val_o !== 1'b1 || rsp_data_o !== exp.data || rsp_err_o !== exp.err || req_rdy_o !== 1'b0)
        hold_ok = 1'b0;
      check("hold_stable", 64'(hold_ok), 64'(1));
    end

    rsp_rdy_i  = 1'b1;
    req_val_i  = 1'b1;
    req_addr_i = 32'h0000_0004;
    check("req_rdy_low_on_complete", 64'(req_rdy_o), 64'(0));
    tick;
    rsp_rdy_i = 1'b0;
    req_val_i = 1'b0;
    check("rsp_val_cleared", 64'(rsp_val_o), 64'(0));
    check("back_to_idle", 64'(req_rdy_o), 64'(1));
    check("no_accept_on_complete", 64'(rom_stb_o), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;
    tick;

    do_read(32'h0000_0008, 2, 32'hFFFF_FFFF, 0, 1'b0);
    do_read(32'h0000_001C, 2, 32'h1111_1111, 0, 1'b0);
    do_read(32'h0000_0006, 2, 32'h2222_2222, 0, 1'b0);
    do_read(32'h0000_0000, 2, 32'h1234_5678, 5, 1'b0);
    do_read(32'h0000_0018, 4, 32'hA5A5_5A5A, 2, 1'b0);
    do_read(32'h0004_0000, 2, 32'h3333_3333, 1, 1'b0);
`ifdef ROM_FETCH_CTRL_TIMEOUT_EN
    do_read(32'h0000_0004, -1, 32'h4444_4444, 0, 1'b1);
    do_read(32'h0000_0014, int'(TIMEOUT), 32'h0F0F_0F0F, 0, 1'b0);
`else
    do_read(32'h0000_0004, 20, 32'h1357_9BDF, 0, 1'b0);
`endif

    // Reset pulse in the middle of ACCESS, followed by a late ack.
    req_addr_i = 32'h0000_000C;
    req_val_i  = 1'b1;
    tick;
    req_val_i = 1'b0;
    check("abort_in_access", 64'(rom_stb_o), 64'(1));
    #2 sys_rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge sys_clk);
    sys_rst_n  = 1'b1;
    rom_ack_i  = 1'b1;
    rom_data_i = 32'hCAFE_F00D;
    tick;
    rom_ack_i = 1'b0;
    check("late_ack_no_rsp", 64'(rsp_val_o), 64'(0));
    check("late_ack_idle", 64'(req_rdy_o), 64'(1));
    tick;
    check("late_ack_no_rsp2", 64'(rsp_val_o), 64'(0));
    do_read(32'h0000_0010, 2, 32'h8765_4321, 0, 1'b0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 SHALL have parameter ROM_WORDS, default 7: number of implemented 32-bit ROM words.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum cycles spent waiting for rom_ack_i.
REQ-003 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: data returned on any error response.
REQ-004 sys_clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_val_i  input  1  core fetch request valid.
REQ-007 req_rdy_o  output  1  controller accepts the request.
REQ-008 req_addr_i  input  32  byte address of the fetch.
REQ-009 rsp_val_o  output  1  response valid.
REQ-010 rsp_rdy_i  input  1  core accepts the response.
REQ-011 rsp_data_o  output  32  fetched word.
REQ-012 rsp_err_o  output  1  response is an error; rsp_data_o = ERR_DATA.
REQ-013 rom_stb_o  output  1  strobe to the ROM.
REQ-014 rom_addr_o  output  16  ROM word index.
REQ-015 rom_ack_i  input  1  ROM acknowledge, registered one cycle after the strobe.
REQ-016 rom_data_i  input  32  ROM read data, valid in the cycle rom_ack_i is high.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 IDLE: req_rdy_o=1; request transfers when req_val_i and req_rdy_o are both high; req_rdy_o=0 in all other states.
REQ-019 On transfer SHALL register word index req_addr_i[17:2]; error if req_addr_i[1:0]!=0, req_addr_i[31:18]!=0, or index >= ROM_WORDS.
REQ-020 Error request: IDLE->RESP with rsp_err_o=1 and rsp_data_o=ERR_DATA; rom_stb_o never asserted for it.
REQ-021 Legal request: IDLE->ACCESS; rom_stb_o=1 and rom_addr_o held stable for the whole of ACCESS.
REQ-022 ACCESS with rom_ack_i=1: capture rom_data_i; rom_stb_o=0 the next cycle; go to RESP with rsp_err_o=0.
REQ-023 Nominal latency: transfer in cycle N, strobe N+1, ack N+2, rsp_val_o N+3.
REQ-024 RESP: rsp_val_o=1 with rsp_data_o and rsp_err_o stable until rsp_rdy_i=1; then go to IDLE.
REQ-025 No new request is accepted in the cycle a response completes; the next transfer is possible one cycle later, in IDLE.
REQ-026 rom_ack_i outside ACCESS is stale and SHALL be ignored without corrupting state.
REQ-027 rsp_val_o SHALL be 0 outside RESP; rom_stb_o SHALL be 0 outside ACCESS.

Reset
REQ-028 While sys_rst_n=0, state SHALL be IDLE: req_rdy_o=1, rsp_val_o=0, rsp_err_o=0, rsp_data_o=0, rom_stb_o=0, rom_addr_o=0, timeout counter=0.
REQ-029 Reset asserted mid-ACCESS or mid-RESP SHALL abort the transaction immediately; no response is issued afterwards.

Configuration
REQ-030 Macro ROM_FETCH_CTRL_TIMEOUT_EN defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack; on reaching TIMEOUT, drop the strobe and go to RESP with rsp_err_o=1, rsp_data_o=ERR_DATA.
REQ-031 Ack arriving in the same cycle the count reaches TIMEOUT SHALL win: normal response.
REQ-032 Macro not defined: no counter is built; ACCESS waits indefinitely for rom_ack_i.

Structure
REQ-033 Shared package selen_mem_pkg SHALL hold the FSM state encoding, ERR_DATA default and the ROM word-address field bounds.
REQ-034 Single flat module; the timeout counter stays inline. No sub-module.

Verification
REQ-035 Read addr 0x8, ROM ack at N+2 with data 0xFFFFFFFF -> rsp_val_o at N+3, data 0xFFFFFFFF, err=0.
REQ-036 Addr 0x1C (index 7, ROM_WORDS=7) -> rsp at N+1, err=1, data 0xDEADBEEF, rom_stb_o never high.
REQ-037 Addr 0x6 (misaligned) -> err=1, no strobe.
REQ-038 rsp_rdy_i low for 5 cycles -> rsp_val_o and data held constant; req_rdy_o=0 throughout.
REQ-039 With TIMEOUT_EN and TIMEOUT=15, ack never returned -> err response 15 cycles after ACCESS entry; repeat with ack in the 15th cycle -> normal data.
REQ-040 sys_rst_n pulsed low during ACCESS -> all outputs at reset values asynchronously; a late ack is ignored; the next request completes normally.
